// File: rtl/data_sram_resp_pkg.sv
// Shared constants and helpers for the data-SRAM responder: MMIO offsets,
// region select default, register reset values and byte-lane merging.
package data_sram_resp_pkg;

    localparam logic [15:0] MMIO_HI_DEF = 16'hBFAF;

    localparam logic [15:0] LED_OFF  = 16'hF000;
    localparam logic [15:0] SW_OFF   = 16'hF004;
    localparam logic [15:0] TMR_OFF  = 16'hE000;
    localparam logic [15:0] CMP_OFF  = 16'hE004;
    localparam logic [15:0] STAT_OFF = 16'hE008;

    localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;
    localparam logic [31:0] LED_RST = 32'h0000_0000;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_LED,
        REG_SW,
        REG_TMR,
        REG_CMP,
        REG_STAT
    } mmio_reg_e;

    // Replace only the byte lanes whose enable is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        return res;
    endfunction

    // Map an MMIO offset onto the register it selects.
    function automatic mmio_reg_e decode_off(input logic [15:0] off);
        case (off)
            LED_OFF:  return REG_LED;
            SW_OFF:   return REG_SW;
            TMR_OFF:  return REG_TMR;
            CMP_OFF:  return REG_CMP;
            STAT_OFF: return REG_STAT;
            default:  return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/data_sram_resp_timer.sv
// Free-running 32-bit timer with a compare register and a sticky interrupt.
module resp_timer
    import data_sram_resp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        tmr_we,
    input  logic        cmp_we,
    input  logic        stat_we,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] timer,
    output logic [31:0] cmp,
    output logic        irq
);

    logic [31:0] timer_nxt;
    logic [31:0] cmp_nxt;
    logic        irq_nxt;

    // Next timer/cmp/irq; the compare uses the old cmp so a CMP write only
    // counts from the following cycle, and a match beats a STATUS clear.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch cannot be inferred.
        timer_nxt = timer + 32'd1;
        cmp_nxt   = cmp;
        irq_nxt   = irq;
        if (tmr_we)
            timer_nxt = byte_merge(timer, wdata, be);
        if (cmp_we)
            cmp_nxt = byte_merge(cmp, wdata, be);
        if (timer_nxt == cmp)
            irq_nxt = 1'b1;
        else if (stat_we)
            irq_nxt = 1'b0;
    end

    // Timer state registers.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (!rst) begin
            timer <= 32'd0;
            cmp   <= CMP_RST;
            irq   <= 1'b0;
        end else begin
            timer <= timer_nxt;
            cmp   <= cmp_nxt;
            irq   <= irq_nxt;
        end
    end

endmodule

// File: rtl/data_sram_resp.sv
// Responder for the core's data-SRAM port: byte-writable RAM plus an MMIO
// block (LED, switches, timer). Reads have a fixed one-cycle latency.
module data_sram_resp
    import data_sram_resp_pkg::*;
#(
    parameter int          RAM_AW  = 14,
    parameter logic [15:0] MMIO_HI = MMIO_HI_DEF,
    parameter int          LED_W   = 16,
    parameter int          SW_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_sram_en,
    input  logic [3:0]        data_sram_wen,
    input  logic [31:0]       data_sram_addr,
    input  logic [31:0]       data_sram_wdata,
    output logic [31:0]       data_sram_rdata,
    output logic [LED_W-1:0]  led,
    input  logic [SW_W-1:0]   switch,
    output logic              timer_irq
);

    logic [31:0]       mem [0:(1<<RAM_AW)-1];
    logic [RAM_AW-1:0] ram_idx;
    logic [31:0]       ram_q;
    logic [31:0]       mmio_q;
    logic              rd_ram_q;

    logic              is_mmio;
    logic              wr_acc;
    logic              rd_acc;
    mmio_reg_e         reg_sel;
    logic [3:0]        ram_be;
    logic              led_we, tmr_we, cmp_we, stat_we;
    logic [31:0]       led_merged;
    logic [31:0]       mmio_rdata;

    logic [SW_W-1:0]   sw_meta;
    logic [SW_W-1:0]   sw_sync;

    logic [31:0]       timer;
    logic [31:0]       cmp;

    assign ram_idx = data_sram_addr[RAM_AW+1:2];

    // Address decode, write strobes and MMIO read mux.
    always_comb begin
        is_mmio    = (data_sram_addr[31:16] == MMIO_HI);
        reg_sel    = decode_off(data_sram_addr[15:0]);
        wr_acc     = data_sram_en && (data_sram_wen != 4'b0000);
        rd_acc     = data_sram_en && (data_sram_wen == 4'b0000);
        ram_be     = (wr_acc && !is_mmio) ? data_sram_wen : 4'b0000;
        led_we     = wr_acc && is_mmio && (reg_sel == REG_LED);
        tmr_we     = wr_acc && is_mmio && (reg_sel == REG_TMR);
        cmp_we     = wr_acc && is_mmio && (reg_sel == REG_CMP);
        stat_we    = wr_acc && is_mmio && (reg_sel == REG_STAT);
        led_merged = byte_merge(32'(led), data_sram_wdata, data_sram_wen);
        mmio_rdata = 32'd0;
        case (reg_sel)
            REG_LED:  mmio_rdata = 32'(led);
            REG_SW:   mmio_rdata = 32'(sw_sync);
            REG_TMR:  mmio_rdata = timer;
            REG_CMP:  mmio_rdata = cmp;
            REG_STAT: mmio_rdata = {31'd0, timer_irq};
            default:  mmio_rdata = 32'd0;
        endcase
    end

    // RAM array with per-byte writes and a registered read port; writes are
    // gated by rst so an access caught by reset never lands.
    always_ff @(posedge clk) begin
        // NOTE: the array and its read register carry no reset so the
        // tools can map them onto block RAM; rdata's reset comes from the
        // select flag below steering the output to the reset MMIO register.
        if (rst) begin
            for (int i = 0; i < 4; i++)
                if (ram_be[i])
                    mem[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            if (rd_acc && !is_mmio)
                ram_q <= mem[ram_idx];
        end
    end

    // Read-source select, MMIO read register, LED and switch synchroniser.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ram_q <= 1'b0;
            mmio_q   <= 32'd0;
            led      <= LED_RST[LED_W-1:0];
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            sw_meta <= switch;
            sw_sync <= sw_meta;
            if (rd_acc) begin
                rd_ram_q <= !is_mmio;
                if (is_mmio)
                    mmio_q <= mmio_rdata;
            end
            if (led_we)
                led <= led_merged[LED_W-1:0];
        end
    end

    assign data_sram_rdata = rd_ram_q ? ram_q : mmio_q;

    resp_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .tmr_we  (tmr_we),
        .cmp_we  (cmp_we),
        .stat_we (stat_we),
        .be      (data_sram_wen),
        .wdata   (data_sram_wdata),
        .timer   (timer),
        .cmp     (cmp),
        .irq     (timer_irq)
    );

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed self-checking bench for data_sram_resp.
module tb_data_sram_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic [15:0] led;
    logic [7:0]  switch;
    logic        timer_irq;

    int checks = 0;
    int errors = 0;

    data_sram_resp dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .led             (led),
        .switch          (switch),
        .timer_irq       (timer_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        data_sram_en    = 1'b1;
        data_sram_wen   = be;
        data_sram_addr  = a;
        data_sram_wdata = d;
        tick();
        data_sram_en  = 1'b0;
        data_sram_wen = 4'b0000;
    endtask

    task automatic rd(input logic [31:0] a);
        data_sram_en   = 1'b1;
        data_sram_wen  = 4'b0000;
        data_sram_addr = a;
        tick();
        data_sram_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b0;
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'b0000;
        data_sram_addr  = 32'd0;
        data_sram_wdata = 32'd0;
        switch          = 8'h00;
        #12;
        check("rst_rdata", data_sram_rdata, 32'h0);
        check("rst_led", 32'(led), 32'h0);
        check("rst_irq", 32'(timer_irq), 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;

        // RAM write then read-after-write
        wr(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        rd(32'h0000_0010);
        check("raw_read", data_sram_rdata, 32'hDEAD_BEEF);

        // Byte-lane merge; rdata holds across a write and while idle
        wr(32'h0000_0020, 32'h1122_3344, 4'hF);
        check("hold_on_write", data_sram_rdata, 32'hDEAD_BEEF);
        wr(32'h0000_0020, 32'hAABB_CCDD, 4'b0101);
        rd(32'h0000_0020);
        check("byte_merge", data_sram_rdata, 32'h11BB_33DD);
        idle(2);
        check("hold_idle", data_sram_rdata, 32'h11BB_33DD);

        // Alias: bit 16 is above the RAM word index
        wr(32'h0001_0004, 32'h5A5A_5A5A, 4'hF);
        rd(32'h0000_0004);
        check("alias", data_sram_rdata, 32'h5A5A_5A5A);

        // LED full and partial writes, readback
        wr(32'hBFAF_F000, 32'h0001_ABCD, 4'hF);
        check("led_write", 32'(led), 32'h0000_ABCD);
        wr(32'hBFAF_F000, 32'h0000_0011, 4'b0001);
        check("led_lane", 32'(led), 32'h0000_AB11);
        rd(32'hBFAF_F000);
        check("led_read", data_sram_rdata, 32'h0000_AB11);

        // Switch through the synchroniser
        switch = 8'h3C;
        idle(2);
        rd(32'hBFAF_F004);
        check("switch_read", data_sram_rdata, 32'h0000_003C);
        rd(32'hBFAF_F010);
        check("unmapped_read", data_sram_rdata, 32'h0);

        // Timer wrap and compare
        wr(32'hBFAF_E004, 32'h0000_0001, 4'hF);
        wr(32'hBFAF_E000, 32'hFFFF_FFFE, 4'hF);
        check("irq_pre", 32'(timer_irq), 32'h0);
        rd(32'hBFAF_E000);
        check("timer_read", data_sram_rdata, 32'hFFFF_FFFE);
        check("irq_at_ffff", 32'(timer_irq), 32'h0);
        idle(1);
        check("irq_at_0", 32'(timer_irq), 32'h0);
        idle(1);
        check("irq_at_1", 32'(timer_irq), 32'h1);
        idle(3);
        check("irq_sticky", 32'(timer_irq), 32'h1);
        rd(32'hBFAF_E008);
        check("status_read", data_sram_rdata, 32'h1);
        wr(32'hBFAF_E008, 32'h0, 4'hF);
        check("irq_clear", 32'(timer_irq), 32'h0);

        // Clear on the same edge as a match: set wins
        wr(32'hBFAF_E000, 32'h0000_0100, 4'hF);
        wr(32'hBFAF_E004, 32'h0000_0105, 4'hF);
        idle(3);
        check("irq_before_match", 32'(timer_irq), 32'h0);
        wr(32'hBFAF_E008, 32'h0, 4'hF);
        check("set_beats_clear", 32'(timer_irq), 32'h1);
        rd(32'hBFAF_E004);
        check("cmp_read", data_sram_rdata, 32'h0000_0105);
        check("irq_hold", 32'(timer_irq), 32'h1);

        // Reset mid-write: access discarded, state reset
        wr(32'h0000_0040, 32'h0102_0304, 4'hF);
        rd(32'h0000_0040);
        check("pre_rst_read", data_sram_rdata, 32'h0102_0304);
        data_sram_en    = 1'b1;
        data_sram_wen   = 4'hF;
        data_sram_addr  = 32'h0000_0040;
        data_sram_wdata = 32'hFFFF_FFFF;
        #3 rst = 1'b0;
        #1;
        check("mid_rst_rdata", data_sram_rdata, 32'h0);
        check("mid_rst_led", 32'(led), 32'h0);
        check("mid_rst_irq", 32'(timer_irq), 32'h0);
        check("mid_rst_timer", dut.u_timer.timer, 32'h0);
        check("mid_rst_cmp", dut.u_timer.cmp, 32'hFFFF_FFFF);
        tick();
        check("rst_edge_timer", dut.u_timer.timer, 32'h0);
        check("rst_edge_rdata", data_sram_rdata, 32'h0);
        data_sram_en  = 1'b0;
        data_sram_wen = 4'b0000;
        rst = 1'b1;
        rd(32'h0000_0040);
        check("no_partial_write", data_sram_rdata, 32'h0102_0304);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
